// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read mode.
// Standard read: 1 cycle rd_en->dout; FWFT: head visible 1 cycle after landing in RAM. Writes blocked when full, reads when empty.
module fifo_sync_param #(
  parameter int data_width = 16,
  parameter int addr_width = 8,
  parameter int data_depth = 256,
  parameter int fwft       = 0,
  parameter int afull_th   = 240,
  parameter int aempty_th  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [data_width-1:0] din,
  input  logic                  rd_en,
  output logic [data_width-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [addr_width:0]   DEPTH_C  = (addr_width+1)'(data_depth);
  localparam logic [addr_width:0]   AFULL_C  = (addr_width+1)'(afull_th);
  localparam logic [addr_width:0]   AEMPTY_C = (addr_width+1)'(aempty_th);
  localparam logic [addr_width:0]   CNT_ONE  = (addr_width+1)'(1);
  localparam logic [addr_width-1:0] PTR_ONE  = (addr_width)'(1);

  logic [data_width-1:0] r_mem [data_depth];
  logic [addr_width-1:0] r_wr_ptr, r_rd_ptr;
  logic [addr_width:0]   r_count;
  logic [data_width-1:0] r_dout;
  logic                  r_valid, r_ovf, r_udf;

  logic                  w_full, w_empty, w_wr_acc, w_rd_acc, w_load;
  logic [addr_width:0]   w_ram_cnt;

  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (fwft != 0) ? ~r_valid : (r_count == '0);
  assign w_wr_acc  = wr_en & ~w_full & ~clr;
  assign w_rd_acc  = rd_en & ~w_empty & ~clr;

  // In FWFT mode count includes the output register, so RAM occupancy excludes it.
  assign w_ram_cnt = r_count - (addr_width+1)'(r_valid);
  assign w_load    = (fwft != 0) ? (~clr & (w_ram_cnt != '0) & (~r_valid | w_rd_acc))
                                 : w_rd_acc;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_load)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CNT_ONE;
      else if (!w_wr_acc && w_rd_acc) r_count <= r_count - CNT_ONE;
      if (wr_en && w_full)  r_ovf <= 1'b1;
      if (rd_en && w_empty) r_udf <= 1'b1;
      // Standard mode pulses valid for one cycle; FWFT holds the head until popped.
      if (w_load) begin
        r_dout  <= r_mem[r_rd_ptr];
        r_valid <= 1'b1;
      end else if ((fwft == 0) || w_rd_acc) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign dout         = r_dout;
  assign valid        = r_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AFULL_C);
  assign almost_empty = (r_count <= AEMPTY_C);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a standard-mode and an FWFT-mode FIFO with the same stimulus and compares both to queue models.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] s_dout, f_dout;
  logic        s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic        f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [8:0]  s_count, f_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.fwft(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf));

  fifo_sync_param #(.fwft(1)) u_ff (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf));

  // Reference state: standard mode
  logic [15:0] qs[$];
  logic [15:0] m_s_dout;
  logic        m_s_valid, m_s_ovf, m_s_udf;
  // Reference state: FWFT mode (m_f_vis = head word is presented)
  logic [15:0] qf[$];
  logic        m_f_vis, m_f_ovf, m_f_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qs.delete(); qf.delete();
    m_s_dout = '0; m_s_valid = 1'b0; m_s_ovf = 1'b0; m_s_udf = 1'b0;
    m_f_vis = 1'b0; m_f_ovf = 1'b0; m_f_udf = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic c, input logic [15:0] d);
    int sz;
    bit pop;
    if (c) begin
      model_reset();
      return;
    end
    sz = qs.size();
    if (w && sz == 256) m_s_ovf = 1'b1;
    if (r && sz == 0)   m_s_udf = 1'b1;
    if (r && sz > 0) begin
      m_s_dout = qs.pop_front();
      m_s_valid = 1'b1;
    end else begin
      m_s_dout = '0;
      m_s_valid = 1'b0;
    end
    if (w && sz < 256) qs.push_back(d);

    sz = qf.size();
    pop = r && m_f_vis;
    if (w && sz == 256) m_f_ovf = 1'b1;
    if (r && !m_f_vis)  m_f_udf = 1'b1;
    if (pop) void'(qf.pop_front());
    if (w && sz < 256) qf.push_back(d);
    // A word becomes visible one edge after it was already held.
    m_f_vis = (sz - int'(pop)) > 0;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] f_exp_dout;
    f_exp_dout = m_f_vis ? qf[0] : 16'h0;
    chk({tag, ":s_count"}, 32'(s_count), 32'(qs.size()));
    chk({tag, ":s_full"},  32'(s_full),  32'(qs.size() == 256));
    chk({tag, ":s_empty"}, 32'(s_empty), 32'(qs.size() == 0));
    chk({tag, ":s_af"},    32'(s_af),    32'(qs.size() >= 240));
    chk({tag, ":s_ae"},    32'(s_ae),    32'(qs.size() <= 16));
    chk({tag, ":s_valid"}, 32'(s_valid), 32'(m_s_valid));
    chk({tag, ":s_dout"},  32'(s_dout),  32'(m_s_dout));
    chk({tag, ":s_ovf"},   32'(s_ovf),   32'(m_s_ovf));
    chk({tag, ":s_udf"},   32'(s_udf),   32'(m_s_udf));
    chk({tag, ":f_count"}, 32'(f_count), 32'(qf.size()));
    chk({tag, ":f_full"},  32'(f_full),  32'(qf.size() == 256));
    chk({tag, ":f_empty"}, 32'(f_empty), 32'(!m_f_vis));
    chk({tag, ":f_af"},    32'(f_af),    32'(qf.size() >= 240));
    chk({tag, ":f_ae"},    32'(f_ae),    32'(qf.size() <= 16));
    chk({tag, ":f_valid"}, 32'(f_valid), 32'(m_f_vis));
    chk({tag, ":f_dout"},  32'(f_dout),  32'(f_exp_dout));
    chk({tag, ":f_ovf"},   32'(f_ovf),   32'(m_f_ovf));
    chk({tag, ":f_udf"},   32'(f_udf),   32'(m_f_udf));
  endtask

  task automatic tick(input string tag, input logic w, input logic r, input logic c, input logic [15:0] d);
    wr_en = w; rd_en = r; clr = c; din = d;
    @(posedge clk);
    #1;
    model_step(w, r, c, d);
    check_all(tag);
  endtask

  initial begin
    logic w, r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Fill with 0..255, then attempt an overflow write, then drain.
    for (int i = 0; i < 256; i++) tick("fill", 1'b1, 1'b0, 1'b0, 16'(i));
    chk("fill_count_std", 32'(s_count), 32'd256);
    chk("fill_count_ff",  32'(f_count), 32'd256);
    tick("ovf", 1'b1, 1'b0, 1'b0, 16'hDEAD);
    for (int i = 0; i < 256; i++) tick("drain", 1'b0, 1'b1, 1'b0, 16'h0);
    tick("idle", 1'b0, 1'b0, 1'b0, 16'h0);
    tick("udf", 1'b0, 1'b1, 1'b0, 16'h0);
    tick("clr_ignores", 1'b1, 1'b1, 1'b1, 16'h1234);
    tick("after_clr", 1'b0, 1'b0, 1'b0, 16'h0);

    // Simultaneous read/write at count 5.
    for (int i = 0; i < 5; i++) tick("pre5", 1'b1, 1'b0, 1'b0, 16'(16'h100 + i));
    for (int i = 0; i < 4; i++) tick("rw5", 1'b1, 1'b1, 1'b0, 16'(16'h200 + i));
    for (int i = 0; i < 6; i++) tick("drain5", 1'b0, 1'b1, 1'b0, 16'h0);

    // Simultaneous at count 0, then at count 256.
    tick("clr0", 1'b0, 1'b0, 1'b1, 16'h0);
    tick("rw0", 1'b1, 1'b1, 1'b0, 16'h0BEE);
    tick("clr1", 1'b0, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 256; i++) tick("fill2", 1'b1, 1'b0, 1'b0, 16'($urandom));
    tick("rwfull", 1'b1, 1'b1, 1'b0, 16'hFACE);
    chk("rwfull_count_std", 32'(s_count), 32'd255);
    tick("clr2", 1'b0, 1'b0, 1'b1, 16'h0);

    // FWFT fall-through latency, then 10 back-to-back pops.
    tick("a5_wr", 1'b1, 1'b0, 1'b0, 16'hA5A5);
    chk("a5_ff_not_yet", 32'(f_valid), 32'd0);
    tick("a5_idle", 1'b0, 1'b0, 1'b0, 16'h0);
    chk("a5_ff_valid", 32'(f_valid), 32'd1);
    chk("a5_ff_dout",  32'(f_dout),  32'h0000A5A5);
    for (int i = 0; i < 9; i++) tick("q10", 1'b1, 1'b0, 1'b0, 16'(16'h300 + i));
    for (int i = 0; i < 11; i++) tick("pop10", 1'b0, 1'b1, 1'b0, 16'h0);
    chk("pop10_ff_empty", 32'(f_empty), 32'd1);

    // Random traffic with occupancy held between 100 and 256.
    tick("clr3", 1'b0, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 150; i++) tick("prefill", 1'b1, 1'b0, 1'b0, 16'($urandom));
    for (int i = 0; i < 1000; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (qs.size() <= 100) r = 1'b0;
      if (qs.size() >= 256) w = 1'b0;
      tick("rand", w, r, 1'b0, 16'($urandom));
    end

    // Asynchronous reset mid-burst at count 37.
    tick("clr4", 1'b0, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 37; i++) tick("burst", 1'b1, 1'b0, 1'b0, 16'(16'h400 + i));
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_count", 32'(s_count), 32'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick("post_rst_wr", 1'b1, 1'b0, 1'b0, 16'(16'h500 + i));
    for (int i = 0; i < 6; i++) tick("post_rst_rd", 1'b0, 1'b1, 1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
